// File: rtl/cond_diff_subtractor16_pipe.sv
// ---------------------------------------------------------------------------
// cond_diff_subtractor16_pipe
//   Pipelined 16-bit conditional-difference subtractor:
//   {Bout, Diff} = x - y - Bin (mod 2^17). The select tree keeps a
//   difference/borrow pair for borrow-in 0 and for borrow-in 1 per group.
//   It merges these pairs at widths 2, 4, 8 and 16, and Bin picks the
//   final pair.
//
//   Pipeline: stage 0 (operand register) -> stage 1 (width-2 pairs)
//             -> [stage 2 (width-4 pairs), PIPE_MID=1 only] -> output.
//   Latency is 2+PIPE_MID cycles. Throughput is one result per cycle.
//
//   Handshake (valid/ready): a transfer occurs on an edge where valid and
//   ready are both high. stall = out_valid & ~out_ready. in_ready = ~stall.
//   While stalled, every stage register and valid bit holds. Otherwise
//   the pipeline advances one stage per cycle.
//
//   Parameters: PIPE_MID (1: register between width-4 and width-8 merges)
//   Optional macro: COND_DIFF_FLAGS_EN adds Z (Diff==0) and V (signed
//   overflow). Both are registered alongside Diff.
//
//   Ports:
//     clk, rst            clock, async active-high reset
//     in_valid/in_ready   operand handshake; x, y, Bin operands
//     out_valid/out_ready result handshake; Diff, Bout results
//     Z, V                flags (COND_DIFF_FLAGS_EN only)
// ---------------------------------------------------------------------------

// One merge level: combines adjacent W-bit groups into 2W-bit groups.
// The upper group's pair is chosen by the lower group's borrow-out.
// This is done separately for borrow-in 0 (d0/b0) and borrow-in 1 (d1/b1).
module cond_diff_merge #(
  parameter int W = 1
) (
  input  logic [15:0]         ad0,
  input  logic [15:0]         ad1,
  input  logic [16/W-1:0]     ab0,
  input  logic [16/W-1:0]     ab1,
  output logic [15:0]         rd0,
  output logic [15:0]         rd1,
  output logic [16/(2*W)-1:0] rb0,
  output logic [16/(2*W)-1:0] rb1
);
  for (genvar g = 0; g < 16 / (2 * W); g++) begin : g_grp
    assign rd0[2*g*W +: W]     = ad0[2*g*W +: W];
    assign rd1[2*g*W +: W]     = ad1[2*g*W +: W];
    assign rd0[(2*g+1)*W +: W] = ab0[2*g] ? ad1[(2*g+1)*W +: W] : ad0[(2*g+1)*W +: W];
    assign rd1[(2*g+1)*W +: W] = ab1[2*g] ? ad1[(2*g+1)*W +: W] : ad0[(2*g+1)*W +: W];
    assign rb0[g]              = ab0[2*g] ? ab1[2*g+1] : ab0[2*g+1];
    assign rb1[g]              = ab1[2*g] ? ab1[2*g+1] : ab0[2*g+1];
  end
endmodule

module cond_diff_subtractor16_pipe #(
  parameter int PIPE_MID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Diff,
  output logic        Bout
`ifdef COND_DIFF_FLAGS_EN
  ,
  output logic        Z,
  output logic        V
`endif
);

  // Side-band data carried with each operand: [0]=Bin, plus the operand
  // sign bits when the overflow flag is built.
`ifdef COND_DIFF_FLAGS_EN
  localparam int SW = 3;
`else
  localparam int SW = 1;
`endif

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // ---------------- stage 0: operand register ----------------
  logic          v0;
  logic [15:0]   x0, y0;
  logic [SW-1:0] side_in, side0;

`ifdef COND_DIFF_FLAGS_EN
  assign side_in = {y[15], x[15], Bin};
`else
  assign side_in = Bin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0    <= 1'b0;
      x0    <= '0;
      y0    <= '0;
      side0 <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      if (in_valid) begin
        x0    <= x;
        y0    <= y;
        side0 <= side_in;
      end
    end
  end

  // ---------------- width-1 pairs, width-2 merge ----------------
  logic [15:0] p_d0, p_d1, p_b0, p_b1;
  assign p_d0 = x0 ^ y0;
  assign p_d1 = ~(x0 ^ y0);
  assign p_b0 = ~x0 & y0;
  assign p_b1 = (~x0 & y0) | ~(x0 ^ y0);

  logic [15:0] w2_d0, w2_d1;
  logic [7:0]  w2_b0, w2_b1;

  cond_diff_merge #(.W(1)) u_m2 (
    .ad0(p_d0), .ad1(p_d1), .ab0(p_b0), .ab1(p_b1),
    .rd0(w2_d0), .rd1(w2_d1), .rb0(w2_b0), .rb1(w2_b1)
  );

  // ---------------- stage 1: width-2 pairs ----------------
  logic          v1;
  logic [15:0]   s1_d0, s1_d1;
  logic [7:0]    s1_b0, s1_b1;
  logic [SW-1:0] side1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      s1_d0 <= '0;
      s1_d1 <= '0;
      s1_b0 <= '0;
      s1_b1 <= '0;
      side1 <= '0;
    end else if (adv) begin
      v1    <= v0;
      s1_d0 <= w2_d0;
      s1_d1 <= w2_d1;
      s1_b0 <= w2_b0;
      s1_b1 <= w2_b1;
      side1 <= side0;
    end
  end

  // ---------------- width-4 merge ----------------
  logic [15:0] w4_d0, w4_d1;
  logic [3:0]  w4_b0, w4_b1;

  cond_diff_merge #(.W(2)) u_m4 (
    .ad0(s1_d0), .ad1(s1_d1), .ab0(s1_b0), .ab1(s1_b1),
    .rd0(w4_d0), .rd1(w4_d1), .rb0(w4_b0), .rb1(w4_b1)
  );

  // ---------------- optional stage 2: width-4 pairs ----------------
  logic          mv;
  logic [15:0]   m_d0, m_d1;
  logic [3:0]    m_b0, m_b1;
  logic [SW-1:0] m_side;

  if (PIPE_MID != 0) begin : g_mid
    logic          v2;
    logic [15:0]   s2_d0, s2_d1;
    logic [3:0]    s2_b0, s2_b1;
    logic [SW-1:0] side2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2    <= 1'b0;
        s2_d0 <= '0;
        s2_d1 <= '0;
        s2_b0 <= '0;
        s2_b1 <= '0;
        side2 <= '0;
      end else if (adv) begin
        v2    <= v1;
        s2_d0 <= w4_d0;
        s2_d1 <= w4_d1;
        s2_b0 <= w4_b0;
        s2_b1 <= w4_b1;
        side2 <= side1;
      end
    end

    assign mv     = v2;
    assign m_d0   = s2_d0;
    assign m_d1   = s2_d1;
    assign m_b0   = s2_b0;
    assign m_b1   = s2_b1;
    assign m_side = side2;
  end else begin : g_nomid
    assign mv     = v1;
    assign m_d0   = w4_d0;
    assign m_d1   = w4_d1;
    assign m_b0   = w4_b0;
    assign m_b1   = w4_b1;
    assign m_side = side1;
  end

  // ---------------- width-8 and width-16 merges ----------------
  logic [15:0] w8_d0, w8_d1, w16_d0, w16_d1;
  logic [1:0]  w8_b0, w8_b1;
  logic        w16_b0, w16_b1;

  cond_diff_merge #(.W(4)) u_m8 (
    .ad0(m_d0), .ad1(m_d1), .ab0(m_b0), .ab1(m_b1),
    .rd0(w8_d0), .rd1(w8_d1), .rb0(w8_b0), .rb1(w8_b1)
  );

  cond_diff_merge #(.W(8)) u_m16 (
    .ad0(w8_d0), .ad1(w8_d1), .ab0(w8_b0), .ab1(w8_b1),
    .rd0(w16_d0), .rd1(w16_d1), .rb0(w16_b0), .rb1(w16_b1)
  );

  // Bin chooses between the borrow-in-0 and borrow-in-1 results.
  logic [15:0] diff_nx;
  logic        bout_nx;
  assign diff_nx = m_side[0] ? w16_d1 : w16_d0;
  assign bout_nx = m_side[0] ? w16_b1 : w16_b0;

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
    end else if (adv) begin
      out_valid <= mv;
      Diff      <= diff_nx;
      Bout      <= bout_nx;
    end
  end

`ifdef COND_DIFF_FLAGS_EN
  // Overflow: operand signs differ and the result sign differs from x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z <= 1'b0;
      V <= 1'b0;
    end else if (adv) begin
      Z <= ~|diff_nx;
      V <= (m_side[1] ^ m_side[2]) & (m_side[1] ^ diff_nx[15]);
    end
  end
`endif

endmodule

// File: tb/tb_cond_diff_subtractor16_pipe.sv
// ---------------------------------------------------------------------------
// tb_cond_diff_subtractor16_pipe
//   Directed bench for cond_diff_subtractor16_pipe (PIPE_MID=1). Each
//   vector carries its hand-computed {Bout, Diff}. A negedge monitor pops
//   the expected queue on every output transfer.
// ---------------------------------------------------------------------------
module tb_cond_diff_subtractor16_pipe;
  localparam int PIPE_MID = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        bout;
`ifdef COND_DIFF_FLAGS_EN
  logic        z_flag, v_flag;
`endif

  int checks = 0;
  int passes = 0;
  logic [16:0] exp_q[$];

  cond_diff_subtractor16_pipe #(.PIPE_MID(PIPE_MID)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .Bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Diff(diff), .Bout(bout)
`ifdef COND_DIFF_FLAGS_EN
    , .Z(z_flag), .V(v_flag)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {15'b0, bout, diff}, 32'hDEAD);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("result", {15'b0, bout, diff}, {15'b0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one operand set and returns just after the accepting edge.
  task automatic drive_op(input logic [15:0] xa, input logic [15:0] ya, input logic ba,
                          input logic [15:0] want_d, input logic want_b);
    int n;
    in_valid = 1'b1;
    x = xa;
    y = ya;
    bin = ba;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    exp_q.push_back({want_b, want_d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_diff", {16'b0, diff}, 32'd0);
    check("reset_bout", {31'b0, bout}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic op and latency
    drive_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
    wait_out_valid(lat);
    check("latency", lat, 2 + PIPE_MID);
    drain("drain_basic");

    // Full borrow ripple
    drive_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    drive_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    drain("drain_ripple");

    // Sign boundary: 0x8000 - 0x7FFF - 1 = 0
    drive_op(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    wait_out_valid(lat);
`ifdef COND_DIFF_FLAGS_EN
    check("flag_z", {31'b0, z_flag}, 32'd1);
    check("flag_v", {31'b0, v_flag}, 32'd1);
`endif
    drain("drain_boundary");

    // Backpressure: stall four cycles once the first result is valid
    drive_op(16'd10, 16'd3, 1'b0, 16'h0007, 1'b0);
    drive_op(16'd3, 16'd10, 1'b0, 16'hFFF9, 1'b1);
    drive_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    wait_out_valid(lat);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_diff", {16'b0, diff}, 32'h0007);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("drain_backpressure");

    // Asynchronous reset with two operations in flight
    drive_op(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0);
    drive_op(16'h0200, 16'h0001, 1'b0, 16'h01FF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_diff", {16'b0, diff}, 32'd0);
    check("async_rst_bout", {31'b0, bout}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_result", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    drive_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
    drain("drain_after_reset");

    // Bubbles: in_valid 1,0,1,0
    drive_op(16'd1, 16'd1, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    drive_op(16'd2, 16'd1, 1'b0, 16'h0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bubble_out_valid", {31'b0, out_valid}, (i == PIPE_MID || i == PIPE_MID + 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    drain("drain_bubbles");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cond_diff_subtractor16_pipe.md
Name: cond_diff_subtractor16_pipe

Overview:
- Pipelined 16-bit conditional-difference subtractor: the subtract-direction counterpart of the team's 16-bit conditional-sum adder.
- Computes {Bout, Diff} = x - y - Bin using the same select tree: per-bit difference/borrow pairs for borrow-in 0 and 1, merged through widths 2, 4, 8 and 16, with the final select by Bin.
- The merge tree is split across register stages with a valid/ready handshake, so it drops directly into the datapath between a producer and a backpressuring consumer.

Parameters:
- PIPE_MID, 1, 1 places a register between the width-4 and width-8 merge levels (latency 3); 0 removes it (latency 2).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set valid
- in_ready  output  1  block accepts operands this cycle
- x  input  16  minuend
- y  input  16  subtrahend
- Bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Diff  output  16  difference
- Bout  output  1  borrow out

Behaviour:
- Arithmetic:
  - {Bout, Diff} = {1'b0,x} - {1'b0,y} - Bin, taken modulo 2^17.
  - Bout = 1 exactly when x < y + Bin (unsigned).
- Per-bit primitive, borrow-in b: d = x^y^b; bo = (~x&y) | (~(x^y)&b).
- Merge at each level: the upper half's pair is selected by the lower half's borrow, exactly as in the adder tree.
- Stage 0 (input register): latches x, y, Bin on accept.
- Stage 1: register after the width-1 and width-2 pairs. The width-2 through width-4 merge is computed from this register.
- Stage 2 (PIPE_MID=1 only): register after the width-4 pairs.
- Output: the width-8, width-16 and Bin selects are registered into Diff/Bout.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - When stalled, every stage register and every valid bit holds.
  - When not stalled, the pipeline advances one stage per cycle. Each stage valid bit takes the previous stage's valid; stage 0 valid takes in_valid && in_ready.
- Latency: a result appears on out_valid exactly 2+PIPE_MID cycles after acceptance when unstalled. Throughput is one per cycle.
- Ordering: results leave in acceptance order. No operand is dropped or duplicated under any out_ready pattern.
- Output stability: while out_valid && !out_ready, Diff and Bout hold their values.
- Reset (asynchronous, any time, including mid-operation):
  - All valid bits clear to 0 and all data registers clear to 0.
  - Outputs: out_valid=0, Diff=16'h0000, Bout=0, in_ready=1.
  - In-flight operations are discarded.
  - The first accept is permitted on the first clock edge after rst deasserts.
- Bubbles: gaps in in_valid propagate as empty stages. Empty stages never raise out_valid.
- Simultaneous accept in and accept out in the same cycle is legal and required at full throughput.

Optional Feature:
- Macro COND_DIFF_FLAGS_EN adds two outputs, registered alongside Diff with identical valid timing, stall-hold and reset-to-0 behaviour:
  - Z (1): Diff == 0.
  - V (1): signed overflow = (x[15] ^ y[15]) & (x[15] ^ Diff[15]), treating Bin as part of the subtrahend; equivalently, the true signed result x - y - Bin lies outside [-32768, 32767].
- Without the macro, Z and V are absent from the port list and no flag logic is built.

Test Plan:
- x=16'h0005, y=16'h0003, Bin=0, out_ready=1 held -> Diff=16'h0002, Bout=0, out_valid exactly 3 cycles after accept (PIPE_MID=1), 2 cycles with PIPE_MID=0.
- Full borrow ripple: x=16'h0000, y=16'h0000, Bin=1 -> Diff=16'hFFFF, Bout=1. Also x=16'h0000, y=16'h0001, Bin=0 -> Diff=16'hFFFF, Bout=1.
- x=16'h8000, y=16'h7FFF, Bin=1 -> Diff=16'h0000, Bout=0; with COND_DIFF_FLAGS_EN: Z=1, V=1.
- Backpressure:
  - Stimulus: back-to-back accepts of (10,3,0), (3,10,0), (16'hFFFF,16'hFFFF,1); out_ready low for 4 cycles once the first result is valid.
  - Required: in_ready low during the stall; Diff stays at 16'h0007 throughout; then 16'h0007/0, 16'hFFF9/1, 16'hFFFF/1 delivered in order with none lost.
- Reset: assert rst asynchronously with 2 operations in flight -> out_valid=0, Diff=0, Bout=0 immediately. After release, no stale result appears, and a new op (x=16'h1234, y=16'h0234, Bin=0) yields 16'h1000/0.
- Bubbles: in_valid pattern 1,0,1,0 with operands (1,1,0), (2,1,0) -> out_valid pattern 1,0,1,0 shifted by latency, with Diff 16'h0000 then 16'h0001.
